// File: rtl/ultra_sonic_pkg.sv
// Shared types and field positions for the ultra_sonic_array sensor block.
package ultra_sonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    GUARD     = 3'd4
  } state_t;

  localparam int unsigned RES_VALID_BIT   = 31;
  localparam int unsigned RES_TIMEOUT_BIT = 30;
  localparam int unsigned STAT_SWEEP_LSB  = 16;
  localparam int unsigned STAT_STATE_LSB  = 8;
  localparam int unsigned STAT_CH_LSB     = 0;

  function automatic logic [31:0] make_result(input logic timeout, input logic [29:0] width);
    logic [31:0] r;
    r = '0;
    r[29:0]            = width;
    r[RES_VALID_BIT]   = 1'b1;
    r[RES_TIMEOUT_BIT] = timeout;
    return r;
  endfunction

  function automatic logic [31:0] make_status(input logic [15:0] sweep, input state_t st,
                                              input logic [3:0] ch);
    logic [31:0] s;
    s = '0;
    s[STAT_SWEEP_LSB +: 16] = sweep;
    s[STAT_STATE_LSB +: 3]  = st;
    s[STAT_CH_LSB +: 4]     = ch;
    return s;
  endfunction

endpackage

// File: rtl/ultra_sonic_array_echo_conditioner.sv
// Per-channel echo input: 2-FF synchroniser, plus a level-persistence filter
// when ULTRA_SONIC_DEGLITCH_EN is defined.
module echo_conditioner #(
  parameter int unsigned DEGLITCH = 4
) (
  input  logic clk,
  input  logic reset_all,
  input  logic echo_raw,
  output logic echo_s
);

  if (DEGLITCH == 0) begin : g_bad_deglitch
    $error("echo_conditioner: DEGLITCH must be at least 1");
  end

  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = echo_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef ULTRA_SONIC_DEGLITCH_EN
  localparam int unsigned RW = $clog2(DEGLITCH + 1);

  logic          filt_q, filt_d;
  logic [RW-1:0] run_q, run_d;

  // Output follows only after DEGLITCH consecutive cycles at the new level.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == RW'(DEGLITCH - 1)) filt_d = sync2_q;
      else                            run_d  = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign echo_s = filt_q;
`else
  assign echo_s = sync2_q;
`endif

endmodule

// File: rtl/ultra_sonic_array.sv
// Round-robin multi-channel ultrasonic ranger with per-channel result registers
// and a status word. Optional echo filter: ULTRA_SONIC_DEGLITCH_EN.
module ultra_sonic_array
  import ultra_sonic_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned GUARD_CYCLES   = 50000,
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned DEGLITCH       = 4
) (
  input  logic                        clk,
  input  logic                        reset_all,
  input  logic                        enable,
  input  logic [$clog2(NUM_CH+1)-1:0] addr,
  output logic [31:0]                 read_data,
  input  logic [NUM_CH-1:0]           echo,
  output logic [NUM_CH-1:0]           pulse
);

  localparam int unsigned AW      = $clog2(NUM_CH + 1);
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [3:0]          ch_q, ch_d;
  logic [15:0]         sweep_q, sweep_d;
  logic [NUM_CH-1:0]   pulse_q, pulse_d;
  logic [31:0]         read_data_q, read_data_d;
  logic [NUM_CH-1:0]   echo_s, echo_prev_q;
  logic [31:0]         res_q [NUM_CH];
  logic [31:0]         res_d [NUM_CH];
  logic                res_we;
  logic [31:0]         res_wdata;
  logic                echo_cur, echo_cur_prev;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    echo_conditioner #(.DEGLITCH(DEGLITCH)) u_cond (
      .clk      (clk),
      .reset_all(reset_all),
      .echo_raw (echo[g]),
      .echo_s   (echo_s[g])
    );
  end

  always_comb begin
    echo_cur      = 1'b0;
    echo_cur_prev = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_q == 4'(i)) begin
        echo_cur      = echo_s[i];
        echo_cur_prev = echo_prev_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_all) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ch_q        <= '0;
      sweep_q     <= '0;
      pulse_q     <= '0;
      read_data_q <= '0;
      echo_prev_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) res_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      sweep_q     <= sweep_d;
      pulse_q     <= pulse_d;
      read_data_q <= read_data_d;
      echo_prev_q <= echo_s;
      res_q       <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    sweep_d   = sweep_q;
    res_we    = 1'b0;
    res_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_CYCLES - 1) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_RISE: begin
        if (echo_cur && !echo_cur_prev) begin
          state_d = MEASURE;
          cnt_d   = 32'd1;
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          res_we    = 1'b1;
          res_wdata = make_result(1'b1, '0);
          state_d   = GUARD;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      MEASURE: begin
        // A saturated width also ends the measurement so the FSM cannot stall.
        if (!echo_cur || cnt_q == TIMEOUT_CYCLES || cnt_q == CNT_MAX) begin
          res_we    = 1'b1;
          res_wdata = make_result(echo_cur, 30'(cnt_q[CNT_W-1:0]));
          state_d   = GUARD;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_CYCLES - 1) begin
          cnt_d   = '0;
          state_d = enable ? TRIG : IDLE;
          if (ch_q == 4'(NUM_CH - 1)) begin
            ch_d    = '0;
            sweep_d = sweep_q + 16'd1;
          end else begin
            ch_d = ch_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Trigger is decoded from the next state so the registered pulse tracks TRIG exactly.
  always_comb begin
    pulse_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pulse_d[i] = (state_d == TRIG) && (ch_d == 4'(i));
    end
  end

  always_comb begin
    res_d       = res_q;
    read_data_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (res_we && ch_q == 4'(i)) res_d[i] = res_wdata;
    end
    if (addr == AW'(NUM_CH)) begin
      read_data_d = make_status(sweep_q, state_q, ch_q);
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (addr == AW'(i)) read_data_d = res_d[i];
      end
    end
  end

  assign pulse     = pulse_q;
  assign read_data = read_data_q;

endmodule
